// File: rtl/eth_frame_receiver_pkg.sv
// Shared constants, state encoding and CRC-32 helper for the Ethernet receive path.
package eth_frame_receiver_pkg;

  localparam int BYTE_LEN      = 8;
  localparam int MAC_LEN       = 6;
  localparam int ETHERTYPE_LEN = 2;
  localparam int HEADER_LEN    = 2 * MAC_LEN + ETHERTYPE_LEN;
  localparam int FCS_LEN       = 4;
  localparam int MIN_FRAME_LEN = HEADER_LEN + FCS_LEN;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;

  localparam logic [4:0]  PRE_CNT_MAX  = 5'd31;
  localparam logic [10:0] BYTE_CNT_MAX = 11'd2047;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD
  } rx_state_t;

  // Reflected CRC-32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32.sv
// Dibit-serial reflected CRC-32 register; i_shift serialises the register out two bits at a time.
module crc32
  import eth_frame_receiver_pkg::*;
(
  input  logic        clk,
  input  logic        i_init,
  input  logic        i_en,
  input  logic        i_shift,
  input  logic [1:0]  i_dibit,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  always_ff @(posedge clk) begin
    if (i_init) begin
      r_crc <= CRC_INIT;
    end else if (i_shift) begin
      r_crc <= {2'b00, r_crc[31:2]};
    end else if (i_en) begin
      r_crc <= crc32_dibit(r_crc, i_dibit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/eth_frame_receiver_dibits_to_bytes.sv
// Packs LSB-first dibits into bytes; the completed byte is presented combinationally with its fourth dibit.
module eth_frame_receiver_dibits_to_bytes
  import eth_frame_receiver_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [1:0]          i_dibit,
  output logic [BYTE_LEN-1:0] o_byte,
  output logic                o_byte_vld,
  output logic [1:0]          o_phase
);

  logic [5:0] r_sh;
  logic [1:0] r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 2'd0;
    end else if (i_clr) begin
      r_phase <= 2'd0;
    end else if (i_en) begin
      r_phase <= r_phase + 2'd1;
    end
  end

  // Oldest dibit ends up in the low bits once three have arrived.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_sh <= {i_dibit, r_sh[5:2]};
    end
  end

  assign o_byte     = {i_dibit, r_sh};
  assign o_byte_vld = i_en && (r_phase == 2'd3);
  assign o_phase    = r_phase;

endmodule

// File: rtl/eth_frame_receiver.sv
// RMII dibit receiver: preamble/SFD detect, header strip, FCS-withholding payload stream, CRC check.
// Optional dst MAC filtering is built when ETH_RX_MAC_FILTER_EN is defined.
module eth_frame_receiver
  import eth_frame_receiver_pkg::*;
#(
  parameter int          MIN_PREAMBLE = 8,
  parameter logic [47:0] MY_MAC       = 48'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inclk,
  input  logic [1:0] in,
  input  logic       in_valid,
  output logic       outclk,
  output logic [7:0] out,
  output logic       done,
  output logic       crc_ok,
  output logic       err
);

  rx_state_t r_state, w_state_nxt;

  logic [4:0]          r_pre_cnt;
  logic [10:0]         r_byte_cnt;
  logic [BYTE_LEN-1:0] r_fifo [FCS_LEN];
  logic [2:0]          r_fifo_cnt;
  logic                r_outclk, r_done, r_crc_ok, r_err;
  logic [7:0]          r_out;

  logic                w_dibit_en, w_in_frame, w_frame_end, w_body_en, w_sfd;
  logic [BYTE_LEN-1:0] w_byte;
  logic                w_byte_vld;
  logic [1:0]          w_phase;
  logic [31:0]         w_crc;
  logic                w_accept, w_push, w_err;

  assign w_dibit_en  = inclk && in_valid;
  assign w_in_frame  = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD);
  assign w_frame_end = w_in_frame && !in_valid;
  assign w_body_en   = w_in_frame && w_dibit_en;
  assign w_sfd       = (r_state == ST_PREAMBLE) && w_dibit_en && (in == SFD_DIBIT) &&
                       (int'(r_pre_cnt) >= MIN_PREAMBLE);

  eth_frame_receiver_dibits_to_bytes u_pack (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_sfd),
    .i_en       (w_body_en),
    .i_dibit    (in),
    .o_byte     (w_byte),
    .o_byte_vld (w_byte_vld),
    .o_phase    (w_phase)
  );

  crc32 u_crc (
    .clk     (clk),
    .i_init  (w_sfd),
    .i_en    (w_body_en),
    .i_shift (1'b0),
    .i_dibit (in),
    .o_crc   (w_crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dibit_en && (in == PRE_DIBIT)) w_state_nxt = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (!in_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (inclk) begin
          if (w_sfd)                 w_state_nxt = ST_HEADER;
          else if (in != PRE_DIBIT)  w_state_nxt = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (!in_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (w_byte_vld && (r_byte_cnt == 11'(HEADER_LEN - 1))) begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!in_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Preamble run length; the dibit that leaves IDLE counts as the first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= 5'd0;
    end else if (w_dibit_en && (in == PRE_DIBIT)) begin
      if (r_state != ST_PREAMBLE)        r_pre_cnt <= 5'd1;
      else if (r_pre_cnt != PRE_CNT_MAX) r_pre_cnt <= r_pre_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= 11'd0;
    end else if (w_sfd) begin
      r_byte_cnt <= 11'd0;
    end else if (w_body_en && w_byte_vld && (r_byte_cnt != BYTE_CNT_MAX)) begin
      r_byte_cnt <= r_byte_cnt + 11'd1;
    end
  end

`ifdef ETH_RX_MAC_FILTER_EN
  logic        r_mac_my, r_mac_bc;
  logic [47:0] w_mac_sh;

  assign w_mac_sh = MY_MAC << {r_byte_cnt[2:0], 3'b000};

  // Match flags are cleared by the first dst byte that disagrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mac_my <= 1'b0;
      r_mac_bc <= 1'b0;
    end else if (w_sfd) begin
      r_mac_my <= 1'b1;
      r_mac_bc <= 1'b1;
    end else if (w_body_en && w_byte_vld && (r_state == ST_HEADER) &&
                 (r_byte_cnt < 11'(MAC_LEN))) begin
      if (w_byte != w_mac_sh[47:40]) r_mac_my <= 1'b0;
      if (w_byte != 8'hFF)           r_mac_bc <= 1'b0;
    end
  end

  assign w_accept = r_mac_my || r_mac_bc;
`else
  logic w_unused_mac;
  assign w_unused_mac = ^MY_MAC;
  assign w_accept     = 1'b1;
`endif

  assign w_push = w_body_en && w_byte_vld && (r_state == ST_PAYLOAD) && w_accept;
  assign w_err  = (r_byte_cnt < 11'(MIN_FRAME_LEN)) || (w_phase != 2'd0) || !w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_cnt <= 3'd0;
      r_outclk   <= 1'b0;
      r_out      <= 8'd0;
      r_done     <= 1'b0;
      r_crc_ok   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_outclk <= 1'b0;
      r_done   <= 1'b0;
      if (w_frame_end) begin
        r_fifo_cnt <= 3'd0;
        r_done     <= 1'b1;
        r_err      <= w_err;
        r_crc_ok   <= !w_err && (w_crc == CRC_RESIDUE);
      end else if (w_sfd) begin
        r_fifo_cnt <= 3'd0;
      end else if (w_push) begin
        if (r_fifo_cnt == 3'(FCS_LEN)) begin
          r_outclk <= 1'b1;
          r_out    <= r_fifo[0];
        end else begin
          r_fifo_cnt <= r_fifo_cnt + 3'd1;
        end
      end
    end
  end

  // Delay line holding back the trailing FCS bytes.
  always_ff @(posedge clk) begin
    if (w_push) begin
      if (r_fifo_cnt == 3'(FCS_LEN)) begin
        r_fifo[0] <= r_fifo[1];
        r_fifo[1] <= r_fifo[2];
        r_fifo[2] <= r_fifo[3];
        r_fifo[3] <= w_byte;
      end else begin
        r_fifo[r_fifo_cnt[1:0]] <= w_byte;
      end
    end
  end

  assign outclk = r_outclk;
  assign out    = r_out;
  assign done   = r_done;
  assign crc_ok = r_crc_ok;
  assign err    = r_err;

endmodule

// File: tb/tb_eth_frame_receiver.sv
// Directed bench for eth_frame_receiver; define ETH_RX_MAC_FILTER_EN to exercise the MAC filter.
module tb_eth_frame_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       tb_inclk;
  logic [1:0] tb_in;
  logic       tb_in_valid;
  logic       outclk;
  logic [7:0] out;
  logic       done;
  logic       crc_ok;
  logic       err;

  always #5 clk = ~clk;

  eth_frame_receiver #(
    .MIN_PREAMBLE (8),
    .MY_MAC       (48'h02_00_00_00_00_01)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inclk    (tb_inclk),
    .in       (tb_in),
    .in_valid (tb_in_valid),
    .outclk   (outclk),
    .out      (out),
    .done     (done),
    .crc_ok   (crc_ok),
    .err      (err)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] cap [0:255];
  int         ncap;
  int         ndone;
  logic       last_ok;
  logic       last_err;

  logic [7:0] fb [0:127];
  int         flen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (outclk) begin
      if (ncap < 256) cap[ncap] = out;
      ncap++;
    end
    if (done) begin
      ndone++;
      last_ok  = crc_ok;
      last_err = err;
    end
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input logic [47:0] dst, input int npay, input int flip_idx);
    logic [31:0] c;
    logic [47:0] src;
    src = 48'h02_00_00_00_00_AA;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = dst[8*(5-i) +: 8];
      fb[6 + i] = src[8*(5-i) +: 8];
    end
    fb[12] = 8'h08;
    fb[13] = 8'h00;
    for (int i = 0; i < npay; i++) fb[14 + i] = 8'(i);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 14 + npay; i++) c = crc_byte(c, fb[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fb[14 + npay + i] = c[8*i +: 8];
    flen = 18 + npay;
    if (flip_idx >= 0) fb[14 + flip_idx] = fb[14 + flip_idx] ^ 8'h01;
  endtask

  task automatic send_dibit(input logic [1:0] d);
    @(negedge clk);
    tb_in       = d;
    tb_inclk    = 1'b1;
    tb_in_valid = 1'b1;
    @(negedge clk);
    tb_inclk    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) send_dibit(b[2*k +: 2]);
  endtask

  task automatic send_frame(input int npre, input int nbytes, input int extra);
    ncap  = 0;
    ndone = 0;
    for (int i = 0; i < 256; i++) cap[i] = 8'hxx;
    for (int i = 0; i < npre; i++) send_dibit(2'b01);
    send_dibit(2'b11);
    for (int i = 0; i < nbytes; i++) send_byte(fb[i]);
    for (int i = 0; i < extra; i++) send_dibit(2'b00);
    @(negedge clk);
    tb_in_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    tb_inclk    = 1'b0;
    tb_in       = 2'b00;
    tb_in_valid = 1'b0;
    ncap        = 0;
    ndone       = 0;
    last_ok     = 1'b0;
    last_err    = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_outclk", 32'(outclk), 32'd0);
    chk("rst_out",    32'(out),    32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_crc_ok", 32'(crc_ok), 32'd0);
    chk("rst_err",    32'(err),    32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good 64-byte frame.
    build(48'h02_00_00_00_00_02, 46, -1);
    send_frame(28, flen, 0);
`ifdef ETH_RX_MAC_FILTER_EN
    chk("filt_nomatch_outclks", 32'(ncap),     32'd0);
    chk("filt_nomatch_done",    32'(ndone),    32'd1);
    chk("filt_nomatch_err",     32'(last_err), 32'd1);
    chk("filt_nomatch_crc_ok",  32'(last_ok),  32'd0);
    build(48'hFF_FF_FF_FF_FF_FF, 46, -1);
    send_frame(28, flen, 0);
`endif
    chk("good_outclks", 32'(ncap),     32'd46);
    for (int i = 0; i < 46; i++) chk($sformatf("good_byte%0d", i), 32'(cap[i]), 32'(i));
    chk("good_done",    32'(ndone),    32'd1);
    chk("good_crc_ok",  32'(last_ok),  32'd1);
    chk("good_err",     32'(last_err), 32'd0);

    // Single bit flipped in payload byte 10.
    build(48'hFF_FF_FF_FF_FF_FF, 46, 10);
    send_frame(28, flen, 0);
    chk("flip_outclks", 32'(ncap),     32'd46);
    chk("flip_byte10",  32'(cap[10]),  32'h0B);
    chk("flip_done",    32'(ndone),    32'd1);
    chk("flip_crc_ok",  32'(last_ok),  32'd0);
    chk("flip_err",     32'(last_err), 32'd0);

    // Preamble too short: header bytes follow but the frame is never opened.
    build(48'hFF_FF_FF_FF_FF_FF, 46, -1);
    send_frame(4, 14, 0);
    chk("shortpre_outclks", 32'(ncap),  32'd0);
    chk("shortpre_done",    32'(ndone), 32'd0);

    // Runt: carrier drops after 10 bytes.
    send_frame(28, 10, 0);
    chk("runt_outclks", 32'(ncap),     32'd0);
    chk("runt_done",    32'(ndone),    32'd1);
    chk("runt_err",     32'(last_err), 32'd1);
    chk("runt_crc_ok",  32'(last_ok),  32'd0);

    // Valid frame followed by one stray dibit.
    send_frame(28, flen, 1);
    chk("misalign_outclks", 32'(ncap),     32'd46);
    chk("misalign_done",    32'(ndone),    32'd1);
    chk("misalign_err",     32'(last_err), 32'd1);
    chk("misalign_crc_ok",  32'(last_ok),  32'd0);

    // Minimum legal frame: header and FCS only.
    build(48'hFF_FF_FF_FF_FF_FF, 0, -1);
    send_frame(10, flen, 0);
    chk("min_outclks", 32'(ncap),     32'd0);
    chk("min_done",    32'(ndone),    32'd1);
    chk("min_err",     32'(last_err), 32'd0);
    chk("min_crc_ok",  32'(last_ok),  32'd1);

    // Reset mid-frame: no done, no output, then recovers.
    build(48'hFF_FF_FF_FF_FF_FF, 46, -1);
    ncap  = 0;
    ndone = 0;
    for (int i = 0; i < 28; i++) send_dibit(2'b01);
    send_dibit(2'b11);
    for (int i = 0; i < 30; i++) send_byte(fb[i]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    tb_in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstmid_outclks", 32'(ncap),  32'd12);
    chk("rstmid_done",    32'(ndone), 32'd0);
    send_frame(28, flen, 0);
    chk("after_rst_outclks", 32'(ncap),    32'd46);
    chk("after_rst_crc_ok",  32'(last_ok), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
